// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result handshake bundle for the shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             in_arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    modport master (
        output in_valid, in_data, in_amt, in_dir, in_arith, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_amt, in_dir, in_arith, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter moving at most STEP bits per cycle between two handshakes
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 16,
    parameter int STEP  = 4
) (
    input logic              clk,
    input logic              rst,
    shift_sequencer_if.slave bus
);
    localparam int REM_W = $clog2(WIDTH + 1);
    localparam logic [REM_W-1:0] FULL = REM_W'(WIDTH);
    localparam logic [REM_W-1:0] STP  = REM_W'(STEP);
    localparam logic [AMT_W-1:0] AMT_FULL = AMT_W'(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, sra;
    logic [REM_W-1:0] rem_q, rem_d, s;
    logic             dir_q, dir_d, arith_q, arith_d;
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_data  = data_q;
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        s       = (rem_q < STP) ? rem_q : STP;
        // the MSB never changes under >>>, so it always equals the original sign bit
        sra     = $signed(data_q) >>> s;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                data_d  = bus.in_data;
                rem_d   = (bus.in_amt >= AMT_FULL) ? FULL : REM_W'(bus.in_amt);
                dir_d   = bus.in_dir;
                arith_d = bus.in_dir && bus.in_arith;
                state_d = SHIFT;
            end
            SHIFT: begin
                data_d  = !dir_q ? data_q << s : arith_q ? sra : data_q >> s;
                rem_d   = rem_q - s;
                state_d = (rem_d == '0) ? DONE : SHIFT;
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of shift results, latency, backpressure and reset abort
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    shift_sequencer_if #(.WIDTH(16), .AMT_W(16)) bus ();
    shift_sequencer #(.WIDTH(16), .AMT_W(16), .STEP(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic req(input logic [15:0] d, input logic [15:0] a, input logic dr, input logic ar, output int n);
        check("in_ready_before_req", {31'd0, bus.in_ready}, 32'd1);
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = dr;
        bus.in_arith = ar;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.in_amt   = 16'd3;
        bus.in_dir   = ~dr;
        bus.in_arith = ~ar;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask
    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_consume", {31'd0, bus.out_valid}, 32'd0);
        check("in_ready_after_consume", {31'd0, bus.in_ready}, 32'd1);
    endtask
    task automatic op(input string tag, input logic [15:0] d, input logic [15:0] a, input logic dr,
                      input logic ar, input logic [15:0] exp_d, input int exp_lat);
        int n;
        req(d, a, dr, ar, n);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, exp_d});
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        consume();
    endtask
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_dir    = 1'b0;
        bus.in_arith  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        op("left1", 16'h0001, 16'd1, 1'b0, 1'b0, 16'h0002, 1);
        op("left0", 16'h0001, 16'd0, 1'b0, 1'b0, 16'h0001, 1);
        op("sra16", 16'h8001, 16'd16, 1'b1, 1'b1, 16'hFFFF, 4);
        op("srl16", 16'h8001, 16'd16, 1'b1, 1'b0, 16'h0000, 4);
        op("srl5", 16'h8000, 16'd5, 1'b1, 1'b0, 16'h0400, 2);
        op("sra5", 16'h8000, 16'd5, 1'b1, 1'b1, 16'hFC00, 2);
        op("left_arith_ignored", 16'h0001, 16'd3, 1'b0, 1'b1, 16'h0008, 1);
        op("sra_pos7", 16'h4F00, 16'd7, 1'b1, 1'b1, 16'h009E, 2);
        op("left_wide_clamp", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 4);
        req(16'h00F0, 16'd100, 1'b0, 1'b0, lat);
        check("clamp_latency", lat, 4);
        check("clamp_data", {16'd0, bus.out_data}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_data", {16'd0, bus.out_data}, 32'd0);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        consume();
        bus.in_data  = 16'hABCD;
        bus.in_amt   = 16'd12;
        bus.in_dir   = 1'b1;
        bus.in_arith = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("abort_busy_shift1", {31'd0, bus.busy}, 32'd1);
        tick();
        check("abort_busy_shift2", {31'd0, bus.out_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_out_data", {16'd0, bus.out_data}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        op("after_abort", 16'h0003, 16'd2, 1'b0, 1'b0, 16'h000C, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
